// File: rtl/sgbm_pkg.sv
// sgbm_pkg: shared cost-vector geometry, frame size and tag helpers for the SGBM pipeline
package sgbm_pkg;
  localparam int DISP_NUM = 96;
  localparam int COST_W = 9;
  localparam int BEAT_DISP = 8;
  localparam int BEATS = DISP_NUM / BEAT_DISP;
  localparam int IMG_ROW = 200;
  localparam int IMG_COL = 400;
  localparam int COST_VEC_W = DISP_NUM * COST_W;
  localparam int TAG_W = 10;
  localparam int BEAT_W = BEAT_DISP * COST_W;
  typedef struct packed {
    logic [COST_VEC_W-1:0] cost;
    logic [TAG_W-1:0] row;
    logic [TAG_W-1:0] col;
  } cost_entry_t;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic logic [2*TAG_W-1:0] next_tag(input logic [TAG_W-1:0] row, input logic [TAG_W-1:0] col);
    return col == TAG_W'(IMG_COL - 1) ?
      {(row == TAG_W'(IMG_ROW - 1) ? TAG_W'(0) : row + 1'b1), TAG_W'(0)} : {row, col + 1'b1};
  endfunction
endpackage

// File: rtl/cost_vec_fifo2.sv
// cost_vec_fifo2: two-entry FIFO of tagged cost vectors; push must only be raised when accepted
module cost_vec_fifo2 import sgbm_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  cost_entry_t wdata,
  output cost_entry_t rdata,
  output logic [1:0]  count,
  output logic        full
);
  cost_entry_t mem_q [2];
  cost_entry_t mem_d [2];
  logic wp_q, wp_d, rp_q, rp_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = wdata;
    wp_d = wp_q ^ push;
    rp_d = rp_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    rdata = mem_q[rp_q];
    count = cnt_q;
    full = cnt_q == 2'd2;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/cost_beat_unpacker.sv
// cost_beat_unpacker: buffers wide cost vectors and replays each as 12 ready/valid beats,
// checking raster order of tags, flagging drops and pulsing at end of frame.
module cost_beat_unpacker import sgbm_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COST_VEC_W-1:0] cost,
  input  logic [TAG_W-1:0]      out_row,
  input  logic [TAG_W-1:0]      out_col,
  input  logic                  valid,
  output logic [BEAT_W-1:0]     m_data,
  output logic [TAG_W-1:0]      m_row,
  output logic [TAG_W-1:0]      m_col,
  output logic [3:0]            m_beat,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  overflow,
  output logic                  order_err,
  output logic                  frame_done
);
  state_t state_q, state_d;
  logic [3:0] beat_q, beat_d;
  logic [TAG_W-1:0] exp_row_q, exp_row_d, exp_col_q, exp_col_d;
  logic overflow_q, overflow_d, order_err_q, order_err_d, frame_done_q, frame_done_d;
  logic hs, pop, push, mismatch, full;
  logic [1:0] count;
  logic [2*TAG_W-1:0] nxt;
  cost_entry_t head;
  cost_vec_fifo2 u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .wdata('{cost: cost, row: out_row, col: out_col}),
    .rdata(head), .count(count), .full(full)
  );
  always_comb begin
    m_valid = state_q == SEND;
    hs = m_valid & m_ready;
    pop = hs & (beat_q == 4'(BEATS - 1));
    push = valid & (!full | pop);
    m_data = m_valid ? head.cost[beat_q * BEAT_W +: BEAT_W] : '0;
    m_row = m_valid ? head.row : '0;
    m_col = m_valid ? head.col : '0;
    m_beat = beat_q;
    m_last = m_valid & (beat_q == 4'(BEATS - 1));
    state_d = state_q;
    beat_d = beat_q;
    if (state_q == IDLE) state_d = (count != 2'd0 || push) ? SEND : IDLE;
    else if (hs) begin
      beat_d = pop ? 4'd0 : beat_q + 4'd1;
      state_d = (pop && count == 2'd1 && !push) ? IDLE : SEND;
    end
    // dropped vectors still advance the raster-order expectation
    mismatch = valid & ((out_row != exp_row_q) | (out_col != exp_col_q));
    nxt = next_tag(mismatch ? out_row : exp_row_q, mismatch ? out_col : exp_col_q);
    exp_row_d = valid ? nxt[2*TAG_W-1:TAG_W] : exp_row_q;
    exp_col_d = valid ? nxt[TAG_W-1:0] : exp_col_q;
    overflow_d = overflow_q | (valid & !push);
    order_err_d = order_err_q | mismatch;
    frame_done_d = pop & (head.row == TAG_W'(IMG_ROW - 1)) & (head.col == TAG_W'(IMG_COL - 1));
    overflow = overflow_q;
    order_err = order_err_q;
    frame_done = frame_done_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q <= 4'd0;
      exp_row_q <= '0;
      exp_col_q <= '0;
      overflow_q <= 1'b0;
      order_err_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      exp_row_q <= exp_row_d;
      exp_col_q <= exp_col_d;
      overflow_q <= overflow_d;
      order_err_q <= order_err_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule
